strela_input_stream_fetcher: RTL

- Address-generating read engine for one CGRA input node.
- Sits directly downstream of the control/status register block and consumes its start-execution pulse plus one node's base address, size and stride.
- Issues OBI-style word reads to memory and buffers the returned data in a small FIFO.
- Presents the data to the CGRA input node over a valid/ready stream and pulses done once every word has been delivered.

---
 rtl/strela_input_stream_fetcher.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/strela_input_stream_fetcher.sv
// Address-generating read engine for one CGRA input node: issues strided word
// reads under a FIFO credit limit and streams the returned data out in order.
module strela_input_stream_fetcher #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [31:0] addr_i,
    input  logic [15:0] size_i,
    input  logic [15:0] stride_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic [31:0] data_o,
    output logic        valid_o,
    input  logic        ready_i,
    output logic        busy_o,
    output logic        done_o
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        addr_q, addr_d;
    logic [15:0]        size_q, size_d;
    logic [15:0]        stride_q, stride_d;
    logic [15:0]        issued_q, issued_d;
    logic [15:0]        deliv_q, deliv_d;
    logic [CNT_W-1:0]   outst_q, outst_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic               req_q, req_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [31:0]        fifo_q [FIFO_DEPTH];

    logic grant;
    logic push;
    logic pop;

    // Responses with nothing outstanding are stale (e.g. issued before a reset).
    assign grant = req_q & mem_gnt_i;
    assign push  = mem_rvalid_i & (outst_q != '0);
    assign pop   = valid_o & ready_i;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        size_d   = size_q;
        stride_d = stride_q;
        issued_d = issued_q;
        deliv_d  = pop ? deliv_q + 16'd1 : deliv_q;
        outst_d  = outst_q + CNT_W'(grant) - CNT_W'(push);
        cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    addr_d   = addr_i;
                    size_d   = size_i;
                    stride_d = stride_i;
                    issued_d = 16'd0;
                    deliv_d  = 16'd0;
                    state_d  = (size_i == 16'd0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                if (grant) begin
                    issued_d = issued_q + 16'd1;
                    addr_d   = addr_q + 32'(stride_q);
                    if ((issued_q + 16'd1) == size_q) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (pop && ((deliv_q + 16'd1) == size_q)) begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Credit: in-flight reads plus buffered words never exceed the FIFO depth.
        req_d  = (state_d == S_FETCH) &&
                 ((SUM_W'(outst_d) + SUM_W'(cnt_d)) < SUM_W'(FIFO_DEPTH));
        busy_d = (state_d == S_FETCH) || (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            size_q   <= '0;
            stride_q <= '0;
            issued_q <= '0;
            deliv_q  <= '0;
            outst_q  <= '0;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            req_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            stride_q <= stride_d;
            issued_q <= issued_d;
            deliv_q  <= deliv_d;
            outst_q  <= outst_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            req_q    <= req_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Data storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= mem_rdata_i;
        end
    end

    assign mem_req_o  = req_q;
    assign mem_addr_o = addr_q;
    assign valid_o    = (cnt_q != '0);
    assign data_o     = valid_o ? fifo_q[rd_ptr_q] : 32'h0;
    assign busy_o     = busy_q;
    assign done_o     = done_q;

endmodule
